// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction
// fetch port and the CPU load/store port. Data wins ties, except that a run of
// MAX_DATA_RUN data grants with fetch waiting forces the next grant to fetch.
// Each access is IDLE -> ISSUE -> RESP; misaligned accesses skip ISSUE and
// never reach the RAM. The ack outputs are also the CPU stall release.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    state_t            state_reg, state_next;
    owner_t            owner_reg, owner_next;
    logic [3:0]        run_cnt_reg, run_cnt_next;
    logic              err_reg, err_next;
    logic              ram_en_reg, ram_en_next;
    logic              ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;

    // Winner-selection scratch values, only meaningful in IDLE.
    logic              pick_data;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;

    // State and RAM-side registers; reset abandons any in-flight access.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= FETCH;
            run_cnt_reg   <= 4'd0;
            err_reg       <= 1'b0;
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            run_cnt_reg   <= run_cnt_next;
            err_reg       <= err_next;
            ram_en_reg    <= ram_en_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, strobe the RAM in ISSUE, answer in RESP.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        run_cnt_next   = run_cnt_reg;
        err_next       = err_reg;
        ram_en_next    = ram_en_reg;
        ram_we_next    = ram_we_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        pick_data      = 1'b0;
        sel_addr       = if_addr;
        sel_we         = 1'b0;
        sel_wdata      = '0;

        case (state_reg)
            IDLE: begin
                if (if_req || d_req) begin
                    // Data wins unless fetch has waited through a full run.
                    pick_data = d_req && (!if_req || (run_cnt_reg != RUN_MAX));
                    if (pick_data) begin
                        owner_next = DATA;
                        sel_addr   = d_addr;
                        sel_we     = d_we;
                        sel_wdata  = d_wdata;
                        if (!if_req)
                            run_cnt_next = 4'd0;
                        else if (run_cnt_reg != RUN_MAX)
                            run_cnt_next = run_cnt_reg + 4'd1;
                    end else begin
                        owner_next   = FETCH;
                        run_cnt_next = 4'd0;
                    end
                    ram_addr_next  = {sel_addr[ADDR_W-1:2], 2'b00};
                    ram_we_next    = sel_we;
                    ram_wdata_next = sel_wdata;
                    if (sel_addr[1:0] == 2'b00) begin
                        ram_en_next = 1'b1;
                        state_next  = ISSUE;
                    end else begin
                        // Misaligned: report immediately, RAM stays untouched.
                        err_next   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            ISSUE: begin
                ram_en_next = 1'b0;
                state_next  = RESP;
            end
            RESP: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Response data is only real RAM data for an aligned read.
    logic [DATA_W-1:0] resp_rdata;
    assign resp_rdata = (ram_we_reg || err_reg) ? '0 : ram_rdata;

    // Per-requester response steering: index 0 is fetch, index 1 is data.
    logic [1:0]        ack_vec;
    logic [1:0]        err_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign ack_vec[gi]   = (state_reg == RESP) && (owner_reg == ((gi == 1) ? DATA : FETCH));
        assign err_vec[gi]   = ack_vec[gi] & err_reg;
        assign rdata_vec[gi] = ack_vec[gi] ? resp_rdata : '0;
    end

    assign if_ack    = ack_vec[0];
    assign if_err    = err_vec[0];
    assign if_rdata  = rdata_vec[0];
    assign d_ack     = ack_vec[1];
    assign d_err     = err_vec[1];
    assign d_rdata   = rdata_vec[1];
    assign ram_en    = ram_en_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model predicts, for every grant,
// which requester wins, the cycle of the RAM strobe, the cycle of the ack and
// the returned data/err. Directed scenarios followed by random traffic.
module tb_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_RUN = 4;

    logic          clk_cpu = 1'b0;
    logic          reset   = 1'b1;
    logic          if_req  = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req   = 1'b0;
    logic          d_we    = 1'b0;
    logic [AW-1:0] d_addr  = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAX_RUN)) dut (
        .clk_cpu(clk_cpu), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Single-port synchronous RAM attached to the arbiter.
    logic [DW-1:0] ram_mem   [0:255];
    logic [DW-1:0] mem_model [0:255];

    always @(posedge clk_cpu) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr[9:2]];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model state (cycle numbers, not FSM states).
    int          cyc;
    int          m_idle_at, m_en_cyc, m_ack_cyc, m_run;
    bit          m_owner_d;
    logic [31:0] m_rdata, m_addr, m_wdata;
    bit          m_err, m_we;

    // Requester behaviour: 0 drop after ack, 1 hold for hold_left acks, 2 random.
    int agent_mode = 0;
    int hold_left  = 0;

    // Observations of the DUT.
    int          en_count, busy_count, if_ack_count, d_ack_count;
    int          grant_n, last_ack_cyc;
    logic [63:0] grant_bits;
    logic [31:0] last_if_rdata, last_d_rdata;
    logic        last_d_err;

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(63, 0)) << 2;
        if ($urandom_range(7, 0) == 0) a = a + 32'($urandom_range(3, 1));
        return a;
    endfunction

    task automatic new_fetch();
        if_req  = 1'b1;
        if_addr = rand_addr();
    endtask

    task automatic new_data();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(1, 0));
        d_addr  = rand_addr();
        d_wdata = $urandom;
    endtask

    task automatic clear_obs();
        en_count = 0; busy_count = 0; if_ack_count = 0; d_ack_count = 0;
        grant_n = 0; grant_bits = '0; last_ack_cyc = -1;
    endtask

    // One clock cycle: called just after a falling edge.
    task automatic step();
        bit ack_here, exp_if_ack, exp_d_ack, exp_busy, exp_en, pick_d;
        logic [31:0] a;
        ack_here   = (cyc == m_ack_cyc);
        exp_if_ack = ack_here && !m_owner_d;
        exp_d_ack  = ack_here && m_owner_d;
        exp_busy   = (cyc < m_idle_at);
        exp_en     = (cyc == m_en_cyc);

        check_eq("ctl{if_ack,d_ack,busy,ram_en}", {if_ack, d_ack, busy, ram_en},
                 {exp_if_ack, exp_d_ack, exp_busy, exp_en});
        if (ack_here) begin
            check_eq("if_resp", {if_err, if_rdata}, exp_if_ack ? {m_err, m_rdata} : 33'h0);
            check_eq("d_resp", {d_err, d_rdata}, exp_d_ack ? {m_err, m_rdata} : 33'h0);
        end
        if (exp_en) begin
            check_eq("ram_addr", ram_addr, m_addr);
            check_eq("ram_we_wdata", {ram_we, ram_wdata}, {m_we, m_wdata});
        end

        if (ram_en) en_count++;
        if (busy) busy_count++;
        if (if_ack || d_ack) begin
            $display("txn cyc=%0d port=%s rdata=%08h err=%0b", cyc, d_ack ? "data" : "fetch",
                     d_ack ? d_rdata : if_rdata, d_ack ? d_err : if_err);
            grant_bits = {grant_bits[62:0], d_ack};
            grant_n++;
            if (agent_mode == 1 && last_ack_cyc >= 0)
                check_eq("grant_spacing", 64'(cyc - last_ack_cyc), 64'd3);
            last_ack_cyc = cyc;
        end
        if (if_ack) begin if_ack_count++; last_if_rdata = if_rdata; end
        if (d_ack) begin d_ack_count++; last_d_rdata = d_rdata; last_d_err = d_err; end

        // Requesters react to the model's view of completion.
        case (agent_mode)
            0: if (ack_here) begin
                if (m_owner_d) d_req = 1'b0; else if_req = 1'b0;
            end
            1: if (ack_here) begin
                hold_left--;
                if (hold_left <= 0) begin if_req = 1'b0; d_req = 1'b0; end
            end
            default: begin
                if (ack_here && !m_owner_d) begin
                    if ($urandom_range(1, 0) == 1) new_fetch(); else if_req = 1'b0;
                end else if (!if_req && $urandom_range(2, 0) == 0) new_fetch();
                else if (if_req && !m_owner_d && cyc < m_ack_cyc) if_addr = $urandom;
                if (ack_here && m_owner_d) begin
                    if ($urandom_range(1, 0) == 1) new_data(); else d_req = 1'b0;
                end else if (!d_req && $urandom_range(2, 0) == 0) new_data();
                else if (d_req && m_owner_d && cyc < m_ack_cyc) begin
                    d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we;
                end
            end
        endcase

        // Model decision for the rising edge that ends this cycle.
        if (reset) begin
            m_idle_at = cyc + 1; m_en_cyc = -1; m_ack_cyc = -1; m_run = 0;
        end else if (cyc >= m_idle_at && (if_req || d_req)) begin
            pick_d = d_req && (!if_req || m_run != MAX_RUN);
            m_owner_d = pick_d;
            if (pick_d) begin
                a = d_addr; m_we = d_we; m_wdata = d_wdata;
                m_run = if_req ? ((m_run < MAX_RUN) ? m_run + 1 : MAX_RUN) : 0;
            end else begin
                a = if_addr; m_we = 1'b0; m_wdata = '0; m_run = 0;
            end
            m_addr = {a[31:2], 2'b00};
            if (a[1:0] != 2'b00) begin
                m_err = 1'b1; m_rdata = '0;
                m_en_cyc = -1; m_ack_cyc = cyc + 1; m_idle_at = cyc + 2;
            end else begin
                m_err = 1'b0;
                if (m_we) begin
                    mem_model[m_addr[9:2]] = m_wdata; m_rdata = '0;
                end else begin
                    m_rdata = mem_model[m_addr[9:2]];
                end
                m_en_cyc = cyc + 1; m_ack_cyc = cyc + 2; m_idle_at = cyc + 3;
            end
        end

        @(negedge clk_cpu);
        cyc++;
    endtask

    task automatic run_quiet(input int max_cyc);
        int n;
        n = 0;
        while ((if_req || d_req || cyc < m_idle_at) && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("drained{if_req,d_req,busy_model}", {if_req, d_req, (cyc < m_idle_at)}, 3'b000);
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram_mem[i] = v;
            mem_model[i] = v;
        end
        ram_mem[16] = 32'hDEAD_BEEF;  mem_model[16] = 32'hDEAD_BEEF;
        clear_obs();
        cyc = 0; m_idle_at = 0; m_en_cyc = -1; m_ack_cyc = -1; m_run = 0; m_owner_d = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk_cpu);
        @(negedge clk_cpu);
        check_eq("rst_ctl", {ram_en, ram_we, busy, if_ack, d_ack, if_err, d_err}, 7'b0);
        check_eq("rst_ram_addr", ram_addr, 32'h0);
        check_eq("rst_ram_wdata", ram_wdata, 32'h0);
        check_eq("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        step();
        reset = 1'b0;

        // Fetch only from 0x40.
        agent_mode = 0; clear_obs();
        if_req = 1'b1; if_addr = 32'h40;
        run_quiet(20);
        check_eq("fetch_rdata", last_if_rdata, 32'hDEAD_BEEF);
        check_eq("fetch_counts{en,if_ack,d_ack}", {8'(en_count), 8'(if_ack_count), 8'(d_ack_count)},
                 {8'd1, 8'd1, 8'd0});

        // Store then load at 0x100.
        clear_obs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        run_quiet(20);
        check_eq("store_rdata", last_d_rdata, 32'h0);
        d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
        run_quiet(20);
        check_eq("load_rdata", last_d_rdata, 32'h1234_5678);

        // Both held: starvation guard pattern, then idle bus, then fetch must win.
        agent_mode = 1; hold_left = 9; clear_obs();
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        run_quiet(60);
        check_eq("grant_count", 64'(grant_n), 64'd9);
        check_eq("grant_order_DDDDFDDDD", grant_bits[8:0], 9'b1_1110_1111);
        clear_obs();
        repeat (10) step();
        check_eq("idle_counts{en,busy,acks}", {8'(en_count), 8'(busy_count), 8'(if_ack_count + d_ack_count)},
                 24'h0);
        hold_left = 1; clear_obs();
        if_req = 1'b1; d_req = 1'b1;
        run_quiet(20);
        check_eq("after_idle_fetch_wins{n,last}", {8'(grant_n), grant_bits[0]}, {8'd1, 1'b0});
        agent_mode = 0;

        // Misaligned data access.
        clear_obs();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h102;
        run_quiet(20);
        check_eq("misalign{en,busy}", {8'(en_count), 8'(busy_count)}, {8'd0, 8'd1});
        check_eq("misalign{err,rdata}", {last_d_err, last_d_rdata}, {1'b1, 32'h0});

        // Reset while a fetch of 0x80 is in ISSUE.
        clear_obs();
        if_req = 1'b1; if_addr = 32'h80;
        step();
        reset = 1'b1; if_req = 1'b0;
        step();
        reset = 1'b0;
        step(); step();
        check_eq("reset_abort_no_ack", 64'(if_ack_count), 64'd0);
        if_req = 1'b1;
        run_quiet(20);
        check_eq("refetch{ack,rdata}", {8'(if_ack_count), last_if_rdata}, {8'd1, mem_model[32]});

        // Random traffic, then drain.
        agent_mode = 2; clear_obs();
        repeat (3000) step();
        agent_mode = 0;
        run_quiet(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
